// File: rtl/sumador_serial_ctrl.sv
// Bit-serial adder sequencer: shifts operands LSB-first through an external
// 1-bit full adder, recirculating the carry, then pulses done with the result.
module sumador_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] ss;
    logic             carry;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] ss_next;

    // Sum bits enter at the top; the oldest bit falls out of the bottom.
    assign ss_next = {fa_s, ss};

    assign fa_a   = (state == ADD) & sa[0];
    assign fa_b   = (state == ADD) & sb[0];
    assign fa_cin = (state == ADD) & carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            ss    <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            if (state == ADD) begin
                ss    <= ss_next[WIDTH-1:1];
                carry <= fa_cout;
                sa    <= sa >> 1;
                sb    <= sb >> 1;
                count <= count + 1'b1;
                if (count == LAST) begin
                    s     <= ss_next;
                    cout  <= fa_cout;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
            end else if (start) begin
                // IDLE and DONE both accept; DONE->ADD gives back-to-back adds.
                sa    <= a;
                sb    <= b;
                carry <= cin;
                count <= '0;
                busy  <= 1'b1;
                state <= ADD;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
